// File: rtl/keypad_pkg.sv
// Key codes, the key result type and the keypad matrix layout shared by the scanner and the entry logic.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR   = 4'd14;
  localparam logic [3:0] KEY_HASH   = 4'd15;
  localparam int         NUM_DIGITS = 3;

  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } key_t;

  localparam key_t KEY_NONE = '{vld: 1'b0, code: 4'd0};

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } entry_state_t;

  function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'ha: code = 4'd9;
      4'hb: code = 4'd12;
      4'hc: code = KEY_STAR;
      4'hd: code = 4'd0;
      4'he: code = KEY_HASH;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic entry_state_t state_of(input logic [1:0] count);
    entry_state_t st;
    if (count == 2'd0) st = EMPTY;
    else if (count == 2'(NUM_DIGITS)) st = FULL;
    else st = PARTIAL;
    return st;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner and debouncer: one key strobe per accepted press, no auto-repeat.
// A full scan of four column periods resolves to a single key or NONE before debouncing.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] iRow,
  output logic [3:0] oCol,
  output logic [3:0] oKey,
  output logic       oKeyStb
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_SCANS);

  typedef enum logic {
    RELEASED,
    PRESSED
  } deb_state_t;

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [1:0]       col, col_nxt;
  logic [1:0]       acc_hits, acc_hits_nxt;
  logic [3:0]       acc_code, acc_code_nxt;
  key_t             last_res, last_res_nxt;
  logic [DEB_W-1:0] same_cnt, same_nxt;
  deb_state_t       deb_state, deb_nxt;
  logic [3:0]       key_q, key_nxt;
  logic             stb_q, stb_nxt;

  logic [3:0] rows_low;
  logic [1:0] col_hits, col_row, scan_hits;
  logic [2:0] hit_sum;
  logic [3:0] scan_code;
  key_t       res;

  always_comb begin
    rows_low = ~iRow;
    col_hits = 2'd0;
    col_row  = 2'd0;
    case (rows_low)
      4'b0000: col_hits = 2'd0;
      4'b0001: begin col_hits = 2'd1; col_row = 2'd0; end
      4'b0010: begin col_hits = 2'd1; col_row = 2'd1; end
      4'b0100: begin col_hits = 2'd1; col_row = 2'd2; end
      4'b1000: begin col_hits = 2'd1; col_row = 2'd3; end
      default: col_hits = 2'd2;
    endcase
    // Contacts saturate at two: anything beyond one key is just "ambiguous".
    hit_sum   = {1'b0, acc_hits} + {1'b0, col_hits};
    scan_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    scan_code = (col_hits == 2'd1) ? map_key(col_row, col) : acc_code;

    res.vld  = (scan_hits == 2'd1);
    res.code = res.vld ? scan_code : 4'd0;

    div_nxt      = div_cnt + DIV_W'(1);
    col_nxt      = col;
    acc_hits_nxt = acc_hits;
    acc_code_nxt = acc_code;
    last_res_nxt = last_res;
    same_nxt     = same_cnt;
    deb_nxt      = deb_state;
    key_nxt      = key_q;
    stb_nxt      = 1'b0;

    if (div_cnt == DIV_LAST) begin
      div_nxt = '0;
      col_nxt = col + 2'd1;
      if (col == 2'd3) begin
        acc_hits_nxt = 2'd0;
        acc_code_nxt = 4'd0;
        last_res_nxt = res;
        if (res == last_res) same_nxt = (same_cnt == DEB_MAX) ? same_cnt : same_cnt + DEB_W'(1);
        else same_nxt = DEB_W'(1);
        case (deb_state)
          RELEASED: if (res.vld && same_nxt == DEB_MAX) begin
            stb_nxt = 1'b1;
            key_nxt = res.code;
            deb_nxt = PRESSED;
          end
          PRESSED: if (!res.vld && same_nxt == DEB_MAX) deb_nxt = RELEASED;
          default: deb_nxt = RELEASED;
        endcase
      end else begin
        acc_hits_nxt = scan_hits;
        acc_code_nxt = scan_code;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      col       <= 2'd0;
      acc_hits  <= 2'd0;
      acc_code  <= 4'd0;
      last_res  <= KEY_NONE;
      same_cnt  <= '0;
      deb_state <= RELEASED;
      key_q     <= 4'd0;
      stb_q     <= 1'b0;
    end else begin
      div_cnt   <= div_nxt;
      col       <= col_nxt;
      acc_hits  <= acc_hits_nxt;
      acc_code  <= acc_code_nxt;
      last_res  <= last_res_nxt;
      same_cnt  <= same_nxt;
      deb_state <= deb_nxt;
      key_q     <= key_nxt;
      stb_q     <= stb_nxt;
    end
  end

  assign oCol    = ~(4'b0001 << col);
  assign oKey    = key_q;
  assign oKeyStb = stb_q;

endmodule

// File: rtl/keypad_num_entry.sv
// Three-digit keypad entry: digits fill a buffer, '*' clears it, '#' on a full buffer
// publishes the number with a one-cycle oNumRdy strobe.
module keypad_num_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] iRow,
  output logic [3:0] oCol,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic       oNumRdy,
  output logic [1:0] oCount
);

  logic [3:0] key;
  logic       key_stb;

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .iRow   (iRow),
    .oCol   (oCol),
    .oKey   (key),
    .oKeyStb(key_stb)
  );

  // Slot 0 holds the first digit typed.
  logic [NUM_DIGITS-1:0][3:0] digit_buf, buf_nxt;
  logic [NUM_DIGITS-1:0][3:0] num_q, num_nxt;
  logic [1:0]                 count, count_nxt;
  logic                       rdy_q, rdy_nxt;
  entry_state_t               state;

  always_comb begin
    state     = state_of(count);
    buf_nxt   = digit_buf;
    count_nxt = count;
    num_nxt   = num_q;
    rdy_nxt   = 1'b0;
    if (key_stb) begin
      if (is_digit(key)) begin
        if (state != FULL) begin
          buf_nxt[count] = key;
          count_nxt      = count + 2'd1;
        end
      end else if (key == KEY_STAR) begin
        buf_nxt   = '0;
        count_nxt = 2'd0;
      end else if (key == KEY_HASH && state == FULL) begin
        num_nxt   = digit_buf;
        rdy_nxt   = 1'b1;
        count_nxt = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_buf <= '0;
      count     <= 2'd0;
      num_q     <= '0;
      rdy_q     <= 1'b0;
    end else begin
      digit_buf <= buf_nxt;
      count     <= count_nxt;
      num_q     <= num_nxt;
      rdy_q     <= rdy_nxt;
    end
  end

  assign oNum1   = num_q[0];
  assign oNum2   = num_q[1];
  assign oNum3   = num_q[2];
  assign oNumRdy = rdy_q;
  assign oCount  = count;

endmodule

// File: tb/tb_keypad_num_entry.sv
// Bench for keypad_num_entry: a keypad matrix model, a key-level entry model and an oNumRdy scoreboard.
module tb_keypad_num_entry;

  localparam int SCAN_DIV  = 4;
  localparam int DEB       = 2;
  localparam int SCAN_CLKS = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] iRow = 4'hF;
  logic [3:0] oCol, oNum1, oNum2, oNum3;
  logic       oNumRdy;
  logic [1:0] oCount;

  keypad_num_entry #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .iRow   (iRow),
    .oCol   (oCol),
    .oNum1  (oNum1),
    .oNum2  (oNum2),
    .oNum3  (oNum3),
    .oNumRdy(oNumRdy),
    .oCount (oCount)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] keys_down = '0;
  string       layout = "123A456B789C*0#D";

  // Entry model: buffered digits, last published number and pending publications.
  logic [3:0]  m_buf[$];
  logic [11:0] m_out = '0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_key(input byte ch);
    if (ch >= 8'h30 && ch <= 8'h39) begin
      if (m_buf.size() < 3) m_buf.push_back(4'(ch - 8'h30));
    end else if (ch == 8'h2A) begin
      m_buf.delete();
    end else if (ch == 8'h23 && m_buf.size() == 3) begin
      m_out = {m_buf[0], m_buf[1], m_buf[2]};
      exp_q.push_back(m_out);
      m_buf.delete();
    end
  endtask

  // Keypad: a held key at (r,c) pulls row r low while column c is driven low.
  always @(negedge clk) begin : keypad
    logic [3:0] r;
    r = 4'hF;
    for (int k = 0; k < 16; k++)
      if (keys_down[k] && !oCol[k % 4]) r[k / 4] = 1'b0;
    iRow = r;
  end

  always @(negedge clk) begin : monitor
    logic        prev;
    logic [11:0] e;
    if (oNumRdy) begin
      check("rdy_single_cycle", {11'd0, prev}, 12'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: pulse with num %0h, expected no pulse at %0t",
                 {oNum1, oNum2, oNum3}, $time);
      end else begin
        e = exp_q.pop_front();
        check("rdy_num", {oNum1, oNum2, oNum3}, e);
      end
    end
    prev = oNumRdy;
  end

  function automatic int key_index(input byte ch);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) if (layout[i] == ch) idx = i;
    return idx;
  endfunction

  task automatic press(input byte ch, input int hold, input int gap);
    int idx;
    idx = key_index(ch);
    model_key(ch);
    keys_down[idx] = 1'b1;
    repeat (hold * SCAN_CLKS) @(posedge clk);
    keys_down[idx] = 1'b0;
    repeat (gap * SCAN_CLKS) @(posedge clk);
    @(negedge clk);
    check("count", {10'd0, oCount}, 12'(m_buf.size()));
    check("num_hold", {oNum1, oNum2, oNum3}, m_out);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ocol"}, {8'd0, oCol}, 12'h00E);
    check({tag, "_count"}, {10'd0, oCount}, 12'd0);
    check({tag, "_num"}, {oNum1, oNum2, oNum3}, 12'd0);
    check({tag, "_rdy"}, {11'd0, oNumRdy}, 12'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ec;
    // Reset and idle column rotation
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    for (int k = 0; k < 20 * SCAN_CLKS; k++) begin
      ec = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check("ocol_rotate", {8'd0, oCol}, {8'd0, ec});
      @(negedge clk);
    end
    check("idle_count", {10'd0, oCount}, 12'd0);

    // Basic entry and publish
    press("4", 4, 4);
    press("2", 4, 4);
    press("7", 4, 4);
    press("#", 4, 4);

    // '#' on a partial buffer, then '*'
    press("5", 4, 4);
    press("6", 4, 4);
    press("#", 4, 4);
    press("*", 4, 4);

    // Letter ignored, fourth digit dropped
    press("1", 4, 4);
    press("2", 4, 4);
    press("A", 4, 4);
    press("3", 4, 4);
    press("9", 4, 4);
    press("#", 4, 4);

    // Contact bounce then a clean hold: one digit only
    for (int s = 0; s < 6; s++) begin
      keys_down[key_index("8")] = (s % 2 == 0);
      repeat (SCAN_CLKS) @(posedge clk);
    end
    press("8", 4, 4);

    // Two keys at once resolve to nothing
    keys_down[key_index("1")] = 1'b1;
    keys_down[key_index("2")] = 1'b1;
    repeat (4 * SCAN_CLKS) @(posedge clk);
    keys_down = '0;
    repeat (4 * SCAN_CLKS) @(negedge clk);
    check("two_keys_count", {10'd0, oCount}, 12'(m_buf.size()));
    press("*", 4, 4);

    // Reset while '#' is held on a full buffer
    press("1", 4, 4);
    press("2", 4, 4);
    press("3", 4, 4);
    keys_down[key_index("#")] = 1'b1;
    repeat (8) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_cleared("async_reset");
    m_buf.delete();
    m_out = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6 * SCAN_CLKS) @(posedge clk);
    model_key("#");
    keys_down = '0;
    repeat (4 * SCAN_CLKS) @(negedge clk);
    check("post_reset_count", {10'd0, oCount}, 12'd0);
    check("post_reset_num", {oNum1, oNum2, oNum3}, m_out);

    // Random key sequences
    for (int n = 0; n < 60; n++) begin
      byte ch;
      repeat ($urandom_range(0, 15)) @(posedge clk);
      if ($urandom_range(0, 1) == 1) ch = 8'h30 + 8'($urandom_range(0, 9));
      else ch = layout[$urandom_range(0, 15)];
      press(ch, $urandom_range(4, 6), $urandom_range(4, 6));
    end

    repeat (4) @(negedge clk);
    check("pending_pulses", 12'(exp_q.size()), 12'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_num_entry.md
# keypad_num_entry

- Scans a 4x4 matrix keypad and debounces it.
- Collects three decimal digits and presents them as `oNum1`, `oNum2`, `oNum3` with a one-cycle `oNumRdy` strobe.
- It is the producing end of the number interface that the game display/control logic consumes. Its outputs connect directly to that block's `iNum1..3` / `iNumRdy`.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles each column is driven, ≥2.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans needed to accept a press or release, ≥1.

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `iRow` in 4: keypad rows, active-low, pulled up externally. Treated as already synchronous; the bench drives it on `clk`.
- `oCol` out 4: keypad column drive, active-low, one-hot-zero.
- `oNum1` out 4: first entered digit, BCD.
- `oNum2` out 4: second entered digit, BCD.
- `oNum3` out 4: third entered digit, BCD.
- `oNumRdy` out 1: one-cycle pulse; `oNum1..3` are valid and new.
- `oCount` out 2: number of digits currently buffered (0–3), for on-screen echo.

## Operation
Key map (row, col):
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: * 0 # D

Key codes:
- digits 0–9 → 0–9
- A–D → 10–13
- `*` → 14
- `#` → 15

Scanner:
- Column index `col` advances 0→1→2→3→0 every `SCAN_DIV` clocks.
- `oCol = ~(4'b0001 << col)`.
- `iRow` is sampled on the last cycle of each column period.
- A full scan is 4 column periods. Its result is:
  - the key code, if exactly one row/col contact was seen;
  - otherwise NONE (zero or ≥2 keys).

Debouncer:
- Counts consecutive full scans with an identical result.
- A press is accepted when a non-NONE result has repeated `DEBOUNCE_SCANS` times while the state is RELEASED. This emits a one-cycle key strobe with the code, then the state goes to PRESSED.
- PRESSED returns to RELEASED after `DEBOUNCE_SCANS` consecutive NONE scans.
- No auto-repeat.
- While PRESSED, a change to a different key is ignored until release.

Entry FSM:
- States: EMPTY, PARTIAL, FULL. State is derived from the digit count: 0 = EMPTY, 1–2 = PARTIAL, 3 = FULL.
- Digit key while count < 3: buffer slot `count` ← digit; count++.
- Digit key while FULL: ignored.
- `*`: clears buffer and count to 0. Outputs are unaffected.
- `#` while FULL: copy buffer → `oNum1..3`, pulse `oNumRdy`, count ← 0.
- `#` while not FULL: ignored, no pulse.
- A–D: ignored.
- `oNum1..3` change only in the `oNumRdy` cycle and hold between entries.
- `oCount` reflects the buffer count.

## Timing
Reset values:
- `oCol = 4'b1110`
- `oNum1..3 = 0`
- `oNumRdy = 0`
- `oCount = 0`
- Scanner, debouncer and buffer all cleared.

Latencies:
- Key strobe occurs in the cycle after the sample that completes the `DEBOUNCE_SCANS`-th matching full scan.
- `oNumRdy` and the new `oNum1..3` are registered and appear 1 clk after the `#` strobe.
- `oCount` updates 1 clk after the digit or `*` strobe.

Rules:
- `oNumRdy` is never high for two consecutive cycles.
- The minimum spacing between pulses is bounded by the debounce period.
- Reset mid-entry (any state, or during a held key) clears the buffer and the outputs immediately (asynchronously). A key still held after reset release must be re-accepted through the full debounce before any action.
- Counter wrap: the column divider wraps at `SCAN_DIV-1`. The debounce counter saturates at `DEBOUNCE_SCANS`.

## Structure
Package `keypad_pkg`:
- `KEY_STAR = 4'd14`, `KEY_HASH = 4'd15`.
- Key code type (4-bit code plus valid bit; NONE = invalid).
- Row/column-to-code mapping function.

Sub-module `keypad_scan`:
- Contains the column divider, row sampling, full-scan resolution and debouncer.
- Ports: `clk`, `reset`, `iRow`, `oCol`, `oKey[3:0]`, `oKeyStb`.

Top `keypad_num_entry` holds the digit buffer, the count and the output registers.

## Test plan
Bench setup: `SCAN_DIV = 4`, `DEBOUNCE_SCANS = 2`, and a keypad model that pulls row r low when its key is pressed and `oCol[c] = 0`.

1. Reset, then no key pressed for 20 scans → `oCol` rotates 1110→1101→1011→0111 every 4 clks; `oNumRdy` stays 0; `oCount = 0`.
2. Press/release 4, 2, 7, then `#`, each held for 4 scans → `oCount` goes 1, 2, 3, 0; a single `oNumRdy` pulse with `oNum1 = 4`, `oNum2 = 2`, `oNum3 = 7`.
3. Press 5, 6, `#` → no pulse and `oCount = 2`. Then `*` → `oCount = 0`, and `oNum1..3` still hold 4, 2, 7.
4. Enter 1, 2, 3, 9 (fourth digit), then `#` → pulse with 1, 2, 3; the 9 is discarded. Key A pressed mid-entry has no effect.
5. Bounce: `iRow` toggles each scan for 6 scans, then holds key 8 → exactly one digit accepted. Keys 1 and 2 pressed together → no key accepted.
6. Assert `reset` while holding `#` with 3 digits buffered → outputs clear within the same cycle. After release with the key still held, no pulse occurs because the buffer is empty.
